// File: rtl/wb_downsizer.sv
// wb_downsizer
//   Wishbone classic bridge from a wide upstream bus (UP_WIDTH) to a narrow
//   downstream slave (DN_WIDTH). Each wide access is split into one narrow
//   beat per data chunk that has at least one sel bit set, lowest chunk
//   first. Read data is reassembled into a buffer. The upstream side gets a
//   single ack/err/rty pulse at the end.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   s_adr_i..s_cyc_i     upstream request (address in UP_WIDTH words)
//   s_dat_o              reassembled read data (read buffer)
//   s_ack_o/err_o/rty_o  upstream termination, one-cycle pulse
//   m_adr_o..m_cyc_o     downstream request (address in DN_WIDTH words)
//   m_dat_i              downstream read data
//   m_ack_i/err_i/rty_i  downstream terminations
//   dbg_state            current FSM state (0 idle, 1 bus, 2 resp)
//
// Handshake: a request is taken when s_cyc_i & s_stb_i are sampled high in
// IDLE. Downstream, m_cyc_o/m_stb_o stay high and every m_* field is held
// until a termination is sampled. The upstream master must drop or replace
// its strobe after the termination pulse. Requests are taken only from the
// cycle after that pulse onward. Dropping s_cyc_i while a beat is
// outstanding aborts the access silently.
// All outputs come straight from flops.

module wb_downsizer #(
  parameter int UP_WIDTH    = 128,
  parameter int DN_WIDTH    = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int GRANULARITY = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ADDR_WIDTH-1:0]           s_adr_i,
  input  logic [UP_WIDTH-1:0]             s_dat_i,
  output logic [UP_WIDTH-1:0]             s_dat_o,
  input  logic                            s_we_i,
  input  logic [UP_WIDTH/GRANULARITY-1:0] s_sel_i,
  input  logic                            s_stb_i,
  input  logic                            s_cyc_i,
  output logic                            s_ack_o,
  output logic                            s_err_o,
  output logic                            s_rty_o,
  output logic [ADDR_WIDTH-1:0]           m_adr_o,
  output logic [DN_WIDTH-1:0]             m_dat_o,
  input  logic [DN_WIDTH-1:0]             m_dat_i,
  output logic                            m_we_o,
  output logic [DN_WIDTH/GRANULARITY-1:0] m_sel_o,
  output logic                            m_stb_o,
  output logic                            m_cyc_o,
  input  logic                            m_ack_i,
  input  logic                            m_err_i,
  input  logic                            m_rty_i,
  output logic [1:0]                      dbg_state
);

  localparam int RATIO  = UP_WIDTH / DN_WIDTH;
  localparam int BW     = $clog2(RATIO);
  localparam int UP_SEL = UP_WIDTH / GRANULARITY;
  localparam int DN_SEL = DN_WIDTH / GRANULARITY;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Request latched in IDLE
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [UP_WIDTH-1:0]   dat_q;
  logic [UP_SEL-1:0]     sel_q;
  logic                  we_q;
  logic [BW-1:0]         beat;

  logic req;
  assign req = s_cyc_i & s_stb_i;

  assign dbg_state = state;

  // Lowest chunk of the incoming request that has any sel bit set
  logic          first_any;
  logic [BW-1:0] first_beat;
  always_comb begin
    first_any  = 1'b0;
    first_beat = '0;
    for (int i = RATIO - 1; i >= 0; i--) begin
      if (s_sel_i[i*DN_SEL +: DN_SEL] != '0) begin
        first_any  = 1'b1;
        first_beat = i[BW-1:0];
      end
    end
  end

  // Next selected chunk strictly above the current beat. Because it is
  // always above, the beat counter never wraps within one access.
  logic          more;
  logic [BW-1:0] nxt_beat;
  always_comb begin
    more     = 1'b0;
    nxt_beat = '0;
    for (int i = RATIO - 1; i >= 0; i--) begin
      if (i > int'(beat) && sel_q[i*DN_SEL +: DN_SEL] != '0) begin
        more     = 1'b1;
        nxt_beat = i[BW-1:0];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. An abort (s_cyc_i low) wins over any termination.
  // Among terminations, err wins over rty, and rty wins over ack.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req) state_nxt = first_any ? BUS : RESP;
      end
      BUS: begin
        if (!s_cyc_i)                state_nxt = IDLE;
        else if (m_err_i || m_rty_i) state_nxt = RESP;
        else if (m_ack_i && !more)   state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: computes the value each registered output takes next cycle
  logic                  m_cyc_nxt, m_stb_nxt, m_we_nxt;
  logic [ADDR_WIDTH-1:0] m_adr_nxt;
  logic [DN_WIDTH-1:0]   m_dat_nxt;
  logic [DN_SEL-1:0]     m_sel_nxt;
  logic                  s_ack_nxt, s_err_nxt, s_rty_nxt;
  logic [BW-1:0]         beat_nxt;

  always_comb begin
    m_cyc_nxt = 1'b0;
    m_stb_nxt = 1'b0;
    m_we_nxt  = 1'b0;
    m_adr_nxt = '0;
    m_dat_nxt = '0;
    m_sel_nxt = '0;
    s_ack_nxt = 1'b0;
    s_err_nxt = 1'b0;
    s_rty_nxt = 1'b0;
    beat_nxt  = beat;
    case (state)
      IDLE: begin
        if (req) begin
          beat_nxt = first_beat;
          if (first_any) begin
            m_cyc_nxt = 1'b1;
            m_stb_nxt = 1'b1;
            m_we_nxt  = s_we_i;
            // Narrow address is the wide address scaled up, with the beat
            // index as its low bits.
            m_adr_nxt = (s_adr_i << BW) | {{(ADDR_WIDTH-BW){1'b0}}, first_beat};
            m_dat_nxt = s_dat_i[first_beat*DN_WIDTH +: DN_WIDTH];
            m_sel_nxt = s_sel_i[first_beat*DN_SEL +: DN_SEL];
          end else begin
            // Nothing selected: terminate right away
            s_ack_nxt = 1'b1;
          end
        end
      end
      BUS: begin
        if (s_cyc_i) begin
          if (m_err_i) begin
            s_err_nxt = 1'b1;
          end else if (m_rty_i) begin
            s_rty_nxt = 1'b1;
          end else if (m_ack_i && !more) begin
            s_ack_nxt = 1'b1;
          end else begin
            // Still waiting on the current beat, or moving to the next one.
            // Either way the downstream cycle stays open.
            if (m_ack_i) beat_nxt = nxt_beat;
            m_cyc_nxt = 1'b1;
            m_stb_nxt = 1'b1;
            m_we_nxt  = we_q;
            m_adr_nxt = (adr_q << BW) | {{(ADDR_WIDTH-BW){1'b0}}, beat_nxt};
            m_dat_nxt = dat_q[beat_nxt*DN_WIDTH +: DN_WIDTH];
            m_sel_nxt = sel_q[beat_nxt*DN_SEL +: DN_SEL];
          end
        end
      end
      default: ;
    endcase
  end

  // The read buffer drives s_dat_o directly. Chunks that are never fetched
  // stay zero because the buffer is cleared when a request is taken.
  logic [UP_WIDTH-1:0] rbuf_nxt;
  always_comb begin
    rbuf_nxt = s_dat_o;
    if (state == IDLE && req) begin
      rbuf_nxt = '0;
    end else if (state == BUS && s_cyc_i && m_ack_i && !m_err_i && !m_rty_i && !we_q) begin
      rbuf_nxt[beat*DN_WIDTH +: DN_WIDTH] = m_dat_i;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      beat    <= '0;
      s_dat_o <= '0;
      s_ack_o <= 1'b0;
      s_err_o <= 1'b0;
      s_rty_o <= 1'b0;
      m_adr_o <= '0;
      m_dat_o <= '0;
      m_sel_o <= '0;
      m_we_o  <= 1'b0;
      m_stb_o <= 1'b0;
      m_cyc_o <= 1'b0;
    end else begin
      if (state == IDLE && req) begin
        adr_q <= s_adr_i;
        dat_q <= s_dat_i;
        sel_q <= s_sel_i;
        we_q  <= s_we_i;
      end
      beat    <= beat_nxt;
      s_dat_o <= rbuf_nxt;
      s_ack_o <= s_ack_nxt;
      s_err_o <= s_err_nxt;
      s_rty_o <= s_rty_nxt;
      m_adr_o <= m_adr_nxt;
      m_dat_o <= m_dat_nxt;
      m_sel_o <= m_sel_nxt;
      m_we_o  <= m_we_nxt;
      m_stb_o <= m_stb_nxt;
      m_cyc_o <= m_cyc_nxt;
    end
  end

endmodule

// File: tb/tb_wb_downsizer.sv
// tb_wb_downsizer
//   Drives upstream requests. A responding slave with memory sits on the
//   narrow side. Each beat is recorded and compared against a transaction
//   level reference model. Directed vectors come from a table, followed by
//   hand-written abort/reset sequences and randomized traffic.

module tb_wb_downsizer;

  localparam int BEAT_W = 69;  // {we, sel[3:0], adr[31:0], dat[31:0]}

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  s_adr_i;
  logic [127:0] s_dat_i;
  logic [127:0] s_dat_o;
  logic         s_we_i;
  logic [15:0]  s_sel_i;
  logic         s_stb_i;
  logic         s_cyc_i;
  logic         s_ack_o, s_err_o, s_rty_o;
  logic [31:0]  m_adr_o;
  logic [31:0]  m_dat_o;
  logic [31:0]  m_dat_i;
  logic         m_we_o;
  logic [3:0]   m_sel_o;
  logic         m_stb_o, m_cyc_o;
  logic         m_ack_i, m_err_i, m_rty_i;
  logic [1:0]   dbg_state;

  wb_downsizer dut (
    .clk(clk), .rst(rst),
    .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_dat_o(s_dat_o), .s_we_i(s_we_i),
    .s_sel_i(s_sel_i), .s_stb_i(s_stb_i), .s_cyc_i(s_cyc_i),
    .s_ack_o(s_ack_o), .s_err_o(s_err_o), .s_rty_o(s_rty_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_we_o(m_we_o),
    .m_sel_o(m_sel_o), .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o),
    .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_rty_i(m_rty_i),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- slave model (narrow side) ----------------
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  int          slv_wait       = 0;
  int          slv_fault_beat = -1;
  logic [2:0]  slv_fault_mask = 3'b001;  // {rty, err, ack} driven on the fault beat
  int          slv_beat_n     = 0;
  int          slv_cnt        = 0;
  logic [BEAT_W-1:0] act_q[$];
  logic [BEAT_W-1:0] exp_q[$];
  int          mcyc_cnt = 0;

  always @(negedge clk) begin
    m_ack_i = 1'b0;
    m_err_i = 1'b0;
    m_rty_i = 1'b0;
    m_dat_i = $urandom;  // junk when not acking
    if (rst || !(m_cyc_o && m_stb_o)) begin
      slv_cnt = 0;
    end else if (slv_cnt < slv_wait) begin
      slv_cnt++;
    end else begin
      slv_cnt = 0;
      act_q.push_back({m_we_o, m_sel_o, m_adr_o, m_dat_o});
      if (slv_beat_n == slv_fault_beat) {m_rty_i, m_err_i, m_ack_i} = slv_fault_mask;
      else m_ack_i = 1'b1;
      m_dat_i = mem[m_adr_o[7:0]];
      if (m_we_o && m_ack_i && !m_err_i && !m_rty_i) begin
        for (int b = 0; b < 4; b++)
          if (m_sel_o[b]) mem[m_adr_o[7:0]][b*8 +: 8] = m_dat_o[b*8 +: 8];
      end
      slv_beat_n++;
    end
  end

  always @(negedge clk) begin
    if (m_cyc_o) mcyc_cnt++;
  end

  // ---------------- reference model (transaction level) ----------------
  // term: 0 ack, 1 err, 2 rty
  task automatic model_xfer(input logic we, input logic [31:0] adr, input logic [15:0] sel,
                            input logic [127:0] wdat, input int fbeat, input logic [2:0] fmask,
                            output int term, output logic [127:0] rdat, output int nb);
    logic        done;
    logic [31:0] wa;
    term = 0;
    rdat = '0;
    nb   = 0;
    done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!done && sel[i*4 +: 4] != 4'h0) begin
        wa = {adr[29:0], 2'b00} + 32'(i);
        exp_q.push_back({we, sel[i*4 +: 4], wa, wdat[i*32 +: 32]});
        if (nb == fbeat && fmask[1]) begin
          term = 1; done = 1'b1;
        end else if (nb == fbeat && fmask[2]) begin
          term = 2; done = 1'b1;
        end else if (we) begin
          for (int b = 0; b < 4; b++)
            if (sel[i*4 + b]) ref_mem[wa[7:0]][b*8 +: 8] = wdat[i*32 + b*8 +: 8];
        end else begin
          rdat[i*32 +: 32] = ref_mem[wa[7:0]];
        end
        nb++;
      end
    end
  endtask

  // ---------------- upstream driver ----------------
  // term: 0 ack, 1 err, 2 rty, 3 several at once, -1 timeout
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [15:0] sel,
                      input logic [127:0] wdat, output int term, output logic [127:0] rdat,
                      output int cyc_n);
    @(negedge clk);
    mcyc_cnt   = 0;
    slv_beat_n = 0;
    act_q.delete();
    s_cyc_i = 1'b1;
    s_stb_i = 1'b1;
    s_we_i  = we;
    s_adr_i = adr;
    s_sel_i = sel;
    s_dat_i = wdat;
    term  = -1;
    rdat  = '0;
    cyc_n = 0;
    for (int n = 1; n <= 200 && term < 0; n++) begin
      @(negedge clk);
      if (s_ack_o || s_err_o || s_rty_o) begin
        case ({s_rty_o, s_err_o, s_ack_o})
          3'b001:  term = 0;
          3'b010:  term = 1;
          3'b100:  term = 2;
          default: term = 3;
        endcase
        rdat  = s_dat_o;
        cyc_n = n;
      end
    end
    if (term < 0) $display("FAIL timeout: no termination within 200 cycles (adr %h sel %h)", adr, sel);
    s_cyc_i = 1'b0;
    s_stb_i = 1'b0;
    s_dat_i = {$urandom, $urandom, $urandom, $urandom};
  endtask

  typedef struct {
    logic         we;
    logic [31:0]  adr;
    logic [15:0]  sel;
    logic [127:0] wdat;
    int           wait_c;
    int           fault_beat;
    logic [2:0]   fault_mask;
    int           exp_term;
    int           exp_nb;
    logic [127:0] exp_rdat;
    int           exp_cyc;
  } vec_t;

  task automatic run_case(input string tag, input vec_t v, input logic use_model);
    int           mterm, mnb, aterm, acyc;
    logic [127:0] mrdat, ardat;
    logic [BEAT_W-1:0] a, e;
    model_xfer(v.we, v.adr, v.sel, v.wdat, v.fault_beat, v.fault_mask, mterm, mrdat, mnb);
    if (use_model) begin
      v.exp_term = mterm;
      v.exp_nb   = mnb;
      v.exp_rdat = mrdat;
      v.exp_cyc  = (mnb == 0) ? 1 : mnb * (v.wait_c + 1) + 1;
    end
    slv_wait       = v.wait_c;
    slv_fault_beat = v.fault_beat;
    slv_fault_mask = v.fault_mask;
    xfer(v.we, v.adr, v.sel, v.wdat, aterm, ardat, acyc);
    check({tag, " term"}, 128'(aterm), 128'(v.exp_term));
    check({tag, " latency"}, 128'(acyc), 128'(v.exp_cyc));
    check({tag, " m_cyc cycles"}, 128'(mcyc_cnt), 128'(v.exp_nb * (v.wait_c + 1)));
    if (v.exp_term == 0 && !v.we) check({tag, " rdata"}, ardat, v.exp_rdat);
    check({tag, " beat count"}, 128'(act_q.size()), 128'(v.exp_nb));
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front();
      e = exp_q.pop_front();
      check({tag, " beat"}, 128'(a), 128'(e));
    end
    act_q.delete();
    exp_q.delete();
    // cycle after the pulse: nothing terminates, downstream idle
    @(negedge clk);
    check({tag, " single pulse"}, {125'd0, s_ack_o, s_err_o, s_rty_o}, 128'd0);
  endtask

  vec_t tbl[10];

  initial begin
    int           term_seen;
    logic [127:0] rd;
    vec_t         rv;

    for (int k = 0; k < 256; k++) begin
      mem[k]     = 32'hA000_0000 + 32'(k);
      ref_mem[k] = 32'hA000_0000 + 32'(k);
    end

    //        we    adr    sel       wdat                                     w  fb  mask    term nb rdat                                       cyc
    tbl[0] = '{1'b0, 32'h10, 16'hFFFF, 128'h0, 1, -1, 3'b001, 0, 4, 128'hA0000043_A0000042_A0000041_A0000040, 9};
    tbl[1] = '{1'b1, 32'h10, 16'h0F00, 128'h11111111_22222222_33333333_44444444, 0, -1, 3'b001, 0, 1, 128'h0, 2};
    tbl[2] = '{1'b0, 32'h10, 16'hF00F, 128'h0, 0, -1, 3'b001, 0, 2, 128'hA0000043_00000000_00000000_A0000040, 3};
    tbl[3] = '{1'b0, 32'h10, 16'hFFFF, 128'h0, 1, 1, 3'b010, 1, 2, 128'h0, 5};
    tbl[4] = '{1'b0, 32'h10, 16'h0000, 128'h0, 0, -1, 3'b001, 0, 0, 128'h0, 1};
    tbl[5] = '{1'b0, 32'h10, 16'h00F0, 128'h0, 0, 0, 3'b101, 2, 1, 128'h0, 2};
    tbl[6] = '{1'b0, 32'h10, 16'hFFFF, 128'h0, 2, 2, 3'b111, 1, 3, 128'h0, 10};
    tbl[7] = '{1'b1, 32'h11, 16'h8001, 128'hDEADBEEF_00000000_00000000_CAFEF00D, 1, -1, 3'b001, 0, 2, 128'h0, 5};
    tbl[8] = '{1'b0, 32'h11, 16'hFFFF, 128'h0, 0, -1, 3'b001, 0, 4, 128'hDE000047_A0000046_A0000045_A000000D, 5};
    tbl[9] = '{1'b0, 32'h10, 16'h0F00, 128'h0, 2, -1, 3'b001, 0, 1, 128'h00000000_22222222_00000000_00000000, 4};

    // reset
    rst = 1'b1;
    s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
    s_adr_i = '0; s_sel_i = '0; s_dat_i = '0;
    repeat (3) @(negedge clk);
    check("reset s_term", {125'd0, s_ack_o, s_err_o, s_rty_o}, 128'd0);
    check("reset m_ctrl", {125'd0, m_cyc_o, m_stb_o, m_we_o}, 128'd0);
    check("reset m_adr/sel/dat", {60'd0, m_sel_o, m_adr_o, m_dat_o}, 128'd0);
    check("reset s_dat_o", s_dat_o, 128'd0);
    rst = 1'b0;
    @(negedge clk);

    // abort: drop s_cyc_i during beat 2, same cycle the slave acks it
    slv_wait = 3; slv_fault_beat = -1; slv_fault_mask = 3'b001;
    slv_beat_n = 0;
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b0;
    s_adr_i = 32'h10; s_sel_i = 16'hFFFF; s_dat_i = '0;
    term_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (s_ack_o || s_err_o || s_rty_o) term_seen++;
    end
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
    @(negedge clk);
    check("abort m_cyc/m_stb drop", {126'd0, m_cyc_o, m_stb_o}, 128'd0);
    repeat (3) begin
      if (s_ack_o || s_err_o || s_rty_o) term_seen++;
      @(negedge clk);
    end
    check("abort no termination", 128'(term_seen), 128'd0);
    run_case("after abort", tbl[0], 1'b0);

    // reset during beat 2
    slv_wait = 3; slv_beat_n = 0;
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b0;
    s_adr_i = 32'h10; s_sel_i = 16'hFFFF;
    term_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (s_ack_o || s_err_o || s_rty_o) term_seen++;
    end
    rst = 1'b1;
    @(negedge clk);
    check("rst m_cyc/m_stb", {126'd0, m_cyc_o, m_stb_o}, 128'd0);
    check("rst s_dat_o", s_dat_o, 128'd0);
    rst = 1'b0;
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (s_ack_o || s_err_o || s_rty_o || m_cyc_o) term_seen++;
    end
    check("rst no termination", 128'(term_seen), 128'd0);
    run_case("after rst", tbl[0], 1'b0);

    // directed table
    for (int t = 0; t < 10; t++) run_case($sformatf("vec%0d", t + 1), tbl[t], 1'b0);

    // randomized traffic against the model
    for (int r = 0; r < 40; r++) begin
      rv.we  = 1'($urandom_range(0, 1));
      rv.adr = 32'($urandom_range(0, 63));
      rv.sel = '0;
      for (int c = 0; c < 4; c++)
        if ($urandom_range(0, 1) == 1) rv.sel[c*4 +: 4] = 4'($urandom_range(1, 15));
      rv.wdat   = {$urandom, $urandom, $urandom, $urandom};
      rv.wait_c = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) begin
        rv.fault_beat = $urandom_range(0, 3);
        rv.fault_mask = 3'($urandom_range(1, 7));
      end else begin
        rv.fault_beat = -1;
        rv.fault_mask = 3'b001;
      end
      rv.exp_term = 0; rv.exp_nb = 0; rv.exp_rdat = '0; rv.exp_cyc = 0;
      run_case($sformatf("rand%0d", r), rv, 1'b1);
    end

    // final memory image must match the model
    rd = '0;
    for (int k = 0; k < 256; k++) if (mem[k] !== ref_mem[k]) rd = rd + 1;
    check("memory image", rd, 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
